sop_delay_pipe: RTL and testbench

//   Programmable sum-of-products evaluator over N_IN inputs, pipelined as invert -> AND -> OR stages.

---
 rtl/sop_pkg.sv | 28 ++
 rtl/sop_delay_stage.sv | 45 ++++
 rtl/sop_delay_pipe.sv | 171 +++++++++++++++++
 tb/tb_sop_delay_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sop_pkg
// Description : Shared types, default sizes and helpers for the
//               sum-of-products delay pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package sop_pkg;

  // Default geometry; the term record width is tied to SOP_N_IN.
  localparam int SOP_N_IN    = 3;
  localparam int SOP_N_TERMS = 4;
  localparam int TOGGLE_W    = 16;

  // One programmable product term.
  typedef struct packed {
    logic                en;
    logic [SOP_N_IN-1:0] care;
    logic [SOP_N_IN-1:0] val;
  } term_t;

  // End-to-end latency of the three stages, in cycles.
  function automatic int sop_total_lat(input int inv, input int and_, input int or_);
    return inv + and_ + or_;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sop_delay_stage.sv
`default_nettype none
// ============================================================================
// Module      : sop_delay_stage
// Description : LAT-deep register chain carrying {valid, data}. All slots
//               move together under a shared advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
module sop_delay_stage #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         busy
);

  logic [LAT-1:0] r_valid;
  logic [W-1:0]   r_data [LAT];

  // Shift the whole chain one slot whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < LAT; i++) r_data[i] <= '0;
    end else if (advance) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= in_data;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign out_valid = r_valid[LAT-1];
  assign out_data  = r_data[LAT-1];
  assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: rtl/sop_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sop_delay_pipe
// Description : Programmable sum-of-products evaluator pipelined as
//               invert -> AND -> OR, each stage a whole number of cycles,
//               with valid/ready flow control and run-time term writes.
//               Optional feature macro: SOP_TOGGLE_CNT_EN adds cnt_clr and a
//               saturating output-toggle counter toggle_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module sop_delay_pipe
  import sop_pkg::*;
#(
  parameter int N_IN    = SOP_N_IN,
  parameter int N_TERMS = SOP_N_TERMS,
  parameter int INV_LAT = 1,
  parameter int AND_LAT = 2,
  parameter int OR_LAT  = 4,
  localparam int c_idx_w = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_y,
  output logic [N_TERMS-1:0] out_terms,
`ifdef SOP_TOGGLE_CNT_EN
  input  logic               cnt_clr,
  output logic [TOGGLE_W-1:0] toggle_cnt,
`endif
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [c_idx_w-1:0] cfg_idx,
  input  logic               cfg_en,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val
);

  localparam int c_inv_w = 2 * N_IN;
  localparam int c_or_w  = 1 + N_TERMS;

  if (INV_LAT < 1 || AND_LAT < 1 || OR_LAT < 1 || N_TERMS < 1 || N_IN != SOP_N_IN) begin : g_bad_params
    $error("sop_delay_pipe: stage latencies and N_TERMS must be >= 1, N_IN must equal SOP_N_IN");
  end

  logic                 w_advance;
  logic                 w_accept;
  logic                 w_cfg_wr;
  logic                 w_inv_valid, w_and_valid;
  logic [c_inv_w-1:0]   w_inv_data;
  logic [N_TERMS-1:0]   w_and_data;
  logic [N_TERMS-1:0]   w_match;
  logic [c_or_w-1:0]    w_or_in;
  logic [c_or_w-1:0]    w_or_data;
  logic                 w_inv_busy, w_and_busy, w_or_busy;
  logic [N_IN-1:0]      w_x, w_nx;
  term_t                r_terms [N_TERMS];

  // Flow control: the whole pipe holds while an output waits for its consumer;
  // a term write on an empty pipe takes the input slot for that cycle.
  assign w_advance = !out_valid || out_ready;
  assign cfg_ready = !(w_inv_busy || w_and_busy || w_or_busy);
  assign w_cfg_wr  = cfg_we && cfg_ready;
  assign in_ready  = w_advance && !w_cfg_wr;
  assign w_accept  = in_valid && in_ready;

  // Term table; an index beyond N_TERMS matches no slot and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TERMS; k++) r_terms[k] <= '0;
    end else if (w_cfg_wr) begin
      for (int k = 0; k < N_TERMS; k++) begin
        if (cfg_idx == c_idx_w'(k)) begin
          r_terms[k].en   <= cfg_en;
          r_terms[k].care <= cfg_care;
          r_terms[k].val  <= cfg_val;
        end
      end
    end
  end

  // Invert stage: both literal polarities travel together.
  sop_delay_stage #(.W(c_inv_w), .LAT(INV_LAT)) u_inv (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (w_advance),
    .in_valid  (w_accept),
    .in_data   ({in_x, ~in_x}),
    .out_valid (w_inv_valid),
    .out_data  (w_inv_data),
    .busy      (w_inv_busy)
  );

  assign w_x  = w_inv_data[c_inv_w-1:N_IN];
  assign w_nx = w_inv_data[N_IN-1:0];

  // Product terms: each cared literal picks the true or inverted rail.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < N_TERMS; k++) begin
      logic m;
      m = r_terms[k].en;
      for (int i = 0; i < N_IN; i++) begin
        if (r_terms[k].care[i]) m = m & (r_terms[k].val[i] ? w_x[i] : w_nx[i]);
      end
      w_match[k] = m;
    end
  end

  // AND stage delay.
  sop_delay_stage #(.W(N_TERMS), .LAT(AND_LAT)) u_and (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (w_advance),
    .in_valid  (w_inv_valid),
    .in_data   (w_match),
    .out_valid (w_and_valid),
    .out_data  (w_and_data),
    .busy      (w_and_busy)
  );

  assign w_or_in = {|w_and_data, w_and_data};

  // OR stage delay; its last slot is the output register.
  sop_delay_stage #(.W(c_or_w), .LAT(OR_LAT)) u_or (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (w_advance),
    .in_valid  (w_and_valid),
    .in_data   (w_or_in),
    .out_valid (out_valid),
    .out_data  (w_or_data),
    .busy      (w_or_busy)
  );

  assign out_y     = w_or_data[c_or_w-1];
  assign out_terms = w_or_data[N_TERMS-1:0];

`ifdef SOP_TOGGLE_CNT_EN
  logic                r_prev_y;
  logic [TOGGLE_W-1:0] r_toggle_cnt;
  logic                w_out_hs;

  assign w_out_hs = out_valid && out_ready;

  // Count handshakes whose result differs from the previous handshake's,
  // saturating; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_y     <= 1'b0;
      r_toggle_cnt <= '0;
    end else begin
      if (w_out_hs) r_prev_y <= out_y;
      if (cnt_clr) begin
        r_toggle_cnt <= '0;
      end else if (w_out_hs && (out_y != r_prev_y) && (r_toggle_cnt != {TOGGLE_W{1'b1}})) begin
        r_toggle_cnt <= r_toggle_cnt + 1'b1;
      end
    end
  end

  assign toggle_cnt = r_toggle_cnt;
`else
  // Toggle counting not built: no extra ports or state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_sop_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sop_delay_pipe
// Description : Scoreboard bench for sop_delay_pipe. Stimulus pushes the
//               expected result into a queue; a monitor pops and compares on
//               every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_delay_pipe;

  localparam int L = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_y;
  logic [2:0] in_x;
  logic [3:0] out_terms;
  logic       cfg_we, cfg_ready, cfg_en;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_care, cfg_val;
`ifdef SOP_TOGGLE_CNT_EN
  logic        cnt_clr;
  logic [15:0] toggle_cnt;
`endif

  sop_delay_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_terms (out_terms),
`ifdef SOP_TOGGLE_CNT_EN
    .cnt_clr   (cnt_clr),
    .toggle_cnt(toggle_cnt),
`endif
    .cfg_we    (cfg_we),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_care  (cfg_care),
    .cfg_val   (cfg_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       y;
    logic [3:0] t;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;

  // Reference term table.
  logic       m_en   [4];
  logic [2:0] m_care [4];
  logic [2:0] m_val  [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_terms(input logic [2:0] x);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_en[k] && (((x ^ m_val[k]) & m_care[k]) == 3'b000);
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_en[k] = 1'b0; m_care[k] = 3'b000; m_val[k] = 3'b000;
    end
  endtask

  // Called and returns at a falling edge; holds in_valid until accepted.
  task automatic send(input logic [2:0] x, input bit lat);
    bit   done;
    exp_t e;
    done = 0;
    in_valid = 1'b1;
    in_x = x;
    for (int n = 0; n < 60 && !done; n++) begin
      #4;
      if (in_ready) begin
        e.t = exp_terms(x); e.y = |e.t; e.acc = cyc + 1; e.lat = lat;
        q.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [2:0] care,
                           input logic [2:0] val, input bit take);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_care = care; cfg_val = val;
    #4;
    chk("cfg_ready_at_write", 32'(cfg_ready), 32'(take));
    @(negedge clk);
    cfg_we = 1'b0;
    if (take) begin
      m_en[idx] = en; m_care[idx] = care; m_val[idx] = val;
    end
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 0;
    for (int n = 0; n < 80; n++) begin
      if (q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
    #4;
    chk("cfg_ready_empty", 32'(cfg_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_ov();
    bit ok;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      #4;
      if (out_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("out_valid_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Monitor: compare every output handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_y", 32'(out_y), 32'(e.y));
          chk("out_terms", 32'(out_terms), 32'(e.t));
          if (e.lat) chk("latency", 32'(cyc + 1 - e.acc), 32'(L));
        end
      end
    end
  end

  initial begin
    logic [2:0] seq8 [8];
    logic [2:0] tog6 [6];
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_care = '0; cfg_val = '0;
`ifdef SOP_TOGGLE_CNT_EN
    cnt_clr = 1'b0;
`endif
    model_clear();
    repeat (3) @(negedge clk);
    #4;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_terms", 32'(out_terms), 32'd0);
`ifdef SOP_TOGGLE_CNT_EN
    chk("rst_toggle_cnt", 32'(toggle_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Program terms: a'b'c', ab'c', ab'c; term3 left disabled.
    cfg_write(2'd0, 1'b1, 3'b111, 3'b000, 1);
    cfg_write(2'd1, 1'b1, 3'b111, 3'b100, 1);
    cfg_write(2'd2, 1'b1, 3'b111, 3'b101, 1);

    // 1: single samples with latency check.
    send(3'b000, 1); wait_empty();
    send(3'b010, 1); wait_empty();
    send(3'b101, 1); wait_empty();

    // 2: all eight inputs back-to-back.
    seq8 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 8; i++) send(seq8[i], 1);
    wait_empty();

    // 3: output stall holds the pipe and its output data.
    out_ready = 1'b0;
    send(3'b000, 0);
    send(3'b101, 0);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_y", 32'(out_y), 32'(q[0].y));
      chk("stall_out_terms", 32'(out_terms), 32'(q[0].t));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_empty();

    // 4: write with samples in flight is dropped; on an empty pipe it lands
    //    and beats a same-cycle input.
    send(3'b010, 0);
    cfg_write(2'd3, 1'b1, 3'b000, 3'b000, 0);
    wait_empty();
    send(3'b010, 0);
    wait_empty();
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_en = 1'b1; cfg_care = 3'b000; cfg_val = 3'b000;
    in_valid = 1'b1; in_x = 3'b010;
    #4;
    chk("wr_wins_in_ready", 32'(in_ready), 32'd0);
    chk("wr_wins_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_we = 1'b0;
    m_en[3] = 1'b1; m_care[3] = 3'b000; m_val[3] = 3'b000;
    send(3'b010, 0);
    send(3'b011, 0);
    send(3'b000, 0);
    wait_empty();

    // 5: reset with four samples in flight.
    for (int i = 0; i < 4; i++) send(3'(i), 0);
    rst_n = 1'b0;
    q.delete();
    model_clear();
    #4;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #4;
      if (i == 3 || i == 9) chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    send(3'b000, 1);
    wait_empty();

`ifdef SOP_TOGGLE_CNT_EN
    // 6: toggle counting 1,0,0,1,1,0 then clear racing a toggle.
    cfg_write(2'd0, 1'b1, 3'b111, 3'b000, 1);
    tog6 = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b010};
    for (int i = 0; i < 6; i++) send(tog6[i], 0);
    wait_empty();
    #4;
    chk("toggle_cnt", 32'(toggle_cnt), 32'd4);
    @(negedge clk);
    out_ready = 1'b0;
    send(3'b000, 0);
    wait_ov();
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #4;
    chk("toggle_cnt_clr", 32'(toggle_cnt), 32'd0);
    @(negedge clk);
`else
    tog6 = '{default: 3'b000};
`endif

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
